i2c_master_arbiter: RTL
=======================

# i2c_master_arbiter

Round-robin arbiter and sequencer that shares one `i2c_master` instance between up to `NUM_REQ` requesters. It accepts one write/read command at a time through a valid/ready handshake and drives the master's `address_in`/`data_in`/`rw`/`start_send` inputs. It tracks transaction completion by watching START/STOP conditions on the shared SDA/SCL lines, because the master exposes no done flag. It sits between the system-side requesters and the `i2c_master`, in the same clock domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CLKS`, 1024: clk cycles allowed from `start_send` to STOP before the transaction is abandoned.
- `GAP_CLKS`, 8: bus-free clk cycles enforced after STOP (or timeout) before the next grant.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester command valid.
- `req_address`  in  7*NUM_REQ  requester i at [7i+6:7i].
- `req_data`  in  8*NUM_REQ  requester i at [8i+7:8i].
- `req_rw`  in  NUM_REQ  0 = write, 1 = read.
- `req_ready`  out  NUM_REQ  one-hot accept; the transfer occurs on the edge where valid&ready.
- `done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `timed_out`  out  1  qualifies `done`: 1 = abandoned on timeout.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `address_out`  out  7  to the master's `address_in`.
- `data_out`  out  8  to the master's `data_in`.
- `rw_out`  out  1  to the master's `rw`.
- `start_send`  out  1  to the master's `start_send`.
- `sda_in`, `scl_in`  in  1 each  taps of the shared bus wires (pulled up).

## Operation
- **Bus monitoring.**
  - `sda_in` and `scl_in` each pass through a 2-flop synchronizer, then a previous-value register. All of these flops reset to 1.
  - START = synchronized SDA falls while synchronized SCL is high in both current and previous samples.
  - STOP = synchronized SDA rises under the same SCL condition.
- **State machine: IDLE → ISSUE → WAIT_START → WAIT_STOP → GAP → IDLE.**
- **IDLE.**
  - `req_ready` is combinational: one-hot for the first valid requester searched upward from the pointer, wrapping modulo NUM_REQ.
  - On the accepting edge: latch that requester's address/data/rw into the output registers, set `grant_id`, set pointer = grant+1 (wrapping), go to ISSUE.
  - With no valid requester, remain in IDLE.
- **ISSUE.** `start_send` = 1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_START.
- **WAIT_START.**
  - START → WAIT_STOP.
  - A STOP seen here is ignored.
- **WAIT_STOP.**
  - STOP → pulse `done[grant_id]` with `timed_out` = 0, go to GAP.
  - A repeated START is ignored.
- **Timeout.**
  - The counter increments every cycle in WAIT_START and WAIT_STOP.
  - Reaching `TIMEOUT_CLKS` before STOP → pulse `done[grant_id]` with `timed_out` = 1, go to GAP.
  - A STOP detected on the same cycle wins: `timed_out` = 0.
- **GAP.** Count `GAP_CLKS` cycles. `req_ready` is all-zero. Then IDLE.
- **Output hold.** `address_out`, `data_out` and `rw_out` hold their value until the next accept.
- **Requester rules.**
  - A requester must hold valid and its fields until it sees ready.
  - Dropping valid before ready withdraws the request without penalty.
- **Reset.** Asserting `reset_n` low at any time returns the block to IDLE immediately:
  - `req_ready`, `done`, `timed_out`, `busy`, `start_send`, `grant_id`, `address_out`, `data_out`, `rw_out` all = 0; pointer = 0.
  - The block does not reset the master. A transaction in flight on the bus is then abandoned, and its owner gets no `done`.

## Timing
- Accept edge → `start_send` high in the next cycle, 1 cycle wide. `busy` rises on the accept edge.
- STOP latency: the first clk edge sampling SDA high starts it; `done` is high after the third edge, for one cycle.
- `timed_out` is meaningful only while `done` is non-zero; otherwise it is 0.
- Minimum spacing between successive `start_send` pulses = bus transaction + 3 (detect) + `GAP_CLKS` + 2 (IDLE, ISSUE) cycles.
- Pointer wrap: after granting NUM_REQ-1, the search starts at 0.

## Test plan
- **Single write.** Master with CLKS_PER_BIT=6; req 0: addr 0x67, data 0xA2, rw 0 → `req_ready[0]` in the same cycle; `start_send` one cycle later; `address_out`=0x67, `data_out`=0xA2; `done[0]`=1 with `timed_out`=0 three edges after the SDA STOP rise; `busy` falls after `GAP_CLKS`.
- **Contention.** All 4 valid simultaneously with data 0x10..0x13 and held → grants in order 0,1,2,3. Then re-assert 2 and 0 → grant 0 (pointer wrapped past 3), then 2.
- **Timeout.** Master `start_send` left unconnected, bus idle high → `done[g]`=1 and `timed_out`=1 exactly `TIMEOUT_CLKS` cycles after ISSUE; next request is granted after GAP.
- **Spurious STOP.** Force an SDA rise with SCL high during WAIT_START → no `done`; the following real START/STOP completes normally.
- **Gap enforcement.** req 1 asserted during GAP → `req_ready` stays 0 until IDLE; grant is issued in the first IDLE cycle.
- **Reset mid-transaction.** Drive `reset_n` low in WAIT_STOP → all outputs 0 asynchronously, no `done`. After release, req 3 is granted before req 1 only if req 1 is not valid (pointer = 0).

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master between NUM_REQ requesters.
// Completion is inferred from START/STOP conditions seen on the shared bus.
module i2c_master_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 1024,
  parameter int GAP_CLKS     = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [7*NUM_REQ-1:0]       req_address,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_rw,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         done,
  output logic                       timed_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [6:0]                 address_out,
  output logic [7:0]                 data_out,
  output logic                       rw_out,
  output logic                       start_send,
  input  logic                       sda_in,
  input  logic                       scl_in
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int CMAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, WAIT_STOP, GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               rw_q, rw_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               to_q, to_d;

  logic [1:0] sda_sync_q, scl_sync_q;
  logic       sda_prev_q, scl_prev_q;
  logic       scl_hi, bus_start, bus_stop;

  logic               found;
  logic [IW-1:0]      pick;
  logic [NUM_REQ-1:0] pick_oh;
  logic               tmo_hit, gap_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_sync_q <= 2'b11;
      scl_sync_q <= 2'b11;
      sda_prev_q <= 1'b1;
      scl_prev_q <= 1'b1;
    end else begin
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_prev_q <= sda_sync_q[1];
      scl_prev_q <= scl_sync_q[1];
    end
  end

  assign scl_hi    = scl_sync_q[1] & scl_prev_q;
  assign bus_start = scl_hi & sda_prev_q & ~sda_sync_q[1];
  assign bus_stop  = scl_hi & ~sda_prev_q & sda_sync_q[1];

  // First valid requester searching upward from the pointer, wrapping.
  always_comb begin
    logic [IW:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  assign pick_oh = found ? (NUM_REQ'(1) << pick) : '0;
  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CLKS - 1));
  assign gap_end = (cnt_q == CW'(GAP_CLKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      done_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    done_d  = '0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          grant_d = pick;
          ptr_d   = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          addr_d  = req_address[7*int'(pick) +: 7];
          data_d  = req_data[8*int'(pick) +: 8];
          rw_d    = req_rw[pick];
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        cnt_d = cnt_q + 1'b1;
        if (tmo_hit) begin
          done_d  = NUM_REQ'(1) << grant_q;
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (bus_start) begin
          state_d = WAIT_STOP;
        end
      end
      WAIT_STOP: begin
        cnt_d = cnt_q + 1'b1;
        // A STOP on the timeout cycle still counts as a clean finish.
        if (bus_stop || tmo_hit) begin
          done_d  = NUM_REQ'(1) << grant_q;
          to_d    = !bus_stop;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (gap_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    start_send = (state_q == ISSUE);
    req_ready  = (state_q == IDLE && reset_n) ? pick_oh : '0;
  end

  assign done        = done_q;
  assign timed_out   = to_q;
  assign grant_id    = grant_q;
  assign address_out = addr_q;
  assign data_out    = data_q;
  assign rw_out      = rw_q;

endmodule
